vblank_scheduler: RTL and testbench

VBLANK_SCHEDULER -- requirements
Module: vblank_scheduler

---
 rtl/vblank_scheduler_pkg.sv | 22 ++
 rtl/vblank_scheduler_rr_pick.sv | 28 ++
 rtl/vblank_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_vblank_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vblank_scheduler_pkg.sv
// Shared types and default timing constants for the vblank update scheduler.
package vblank_scheduler_pkg;

    localparam int unsigned V_DISP_DEF    = 480;
    localparam int unsigned V_WIN_END_DEF = 520;
    localparam int unsigned V_LAST_LINE   = 524;
    localparam int unsigned NREQ_DEF      = 4;
    localparam int unsigned CNT_W         = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_GRANT = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_e;

    // Pointer width for n requesters; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vblank_scheduler_rr_pick.sv
// Combinational round-robin finder: first pending index at or after the pointer.
module vblank_scheduler_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  pending_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic          valid_o
);

    logic [PW-1:0] idx;

    // Scan N positions starting at the pointer, wrapping modulo N.
    always_comb begin
        onehot_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr_i) + i) % N);
            if (!valid_o && pending_i[idx]) begin
                onehot_o[idx] = 1'b1;
                valid_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vblank_scheduler.sv
// Vertical-blank update scheduler: hands one-at-a-time, round-robin grants to
// game-logic requesters while the vblank window is open.
// Optional build macro VBLANK_SCHED_WDT_EN adds a grant-hold watchdog.
module vblank_scheduler
    import vblank_scheduler_pkg::*;
#(
    parameter int unsigned vDisp    = V_DISP_DEF,
    parameter int unsigned vWinEnd  = V_WIN_END_DEF,
    parameter int unsigned NREQ     = NREQ_DEF,
    parameter int unsigned HOLD_MAX = 4096
) (
    input  logic             pixClk,
    input  logic             rst,
    input  logic [CNT_W-1:0] horiz_counter,
    input  logic [CNT_W-1:0] vert_counter,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  done,
    output logic [NREQ-1:0]  gnt,
    output logic             frame_tick,
    output logic             window_open,
    output logic             overrun,
    output logic [NREQ-1:0]  err_mask
);

    localparam int unsigned PTR_W = ptr_width(NREQ);

    // Reject parameter sets the window logic cannot honour.
    if (!((vDisp < vWinEnd) && (vWinEnd <= V_LAST_LINE)) || (HOLD_MAX == 0)) begin : g_bad_params
        $error("vblank_scheduler: invalid window or hold parameters");
    end

    sched_state_e     state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  served_q, served_d;
    logic [NREQ-1:0]  err_q, err_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             overrun_q, overrun_d;
    logic             frame_tick_q;
    logic             win_q;

    logic             win_open_c;
    logic             win_close_c;
    logic             done_hit_c;
    logic             wdt_expire_c;
    logic [NREQ-1:0]  pending_c;
    logic [NREQ-1:0]  pick_onehot_c;
    logic             pick_valid_c;
    logic [PTR_W-1:0] ptr_adv_c;

    assign win_open_c  = (vert_counter == CNT_W'(vDisp)) && (horiz_counter == '0);
    assign win_close_c = (vert_counter == CNT_W'(vWinEnd + 1)) && (horiz_counter == '0);
    assign done_hit_c  = |(done & gnt_q);
    assign pending_c   = req & ~served_q;

    vblank_scheduler_rr_pick #(
        .N  (NREQ),
        .PW (PTR_W)
    ) u_rr_pick (
        .pending_i (pending_c),
        .ptr_i     (ptr_q),
        .onehot_o  (pick_onehot_c),
        .valid_o   (pick_valid_c)
    );

    // Pointer value one past the currently granted requester.
    always_comb begin
        ptr_adv_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                ptr_adv_c = PTR_W'((i + 1) % NREQ);
            end
        end
    end

`ifdef VBLANK_SCHED_WDT_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    // Hold counter: zero outside a grant, counts grant cycles otherwise.
    always_comb begin
        hold_d = '0;
        if ((state_q == ST_GRANT) || (state_q == ST_DRAIN)) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    // Hold counter register.
    always_ff @(posedge pixClk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign wdt_expire_c = ((state_q == ST_GRANT) || (state_q == ST_DRAIN)) &&
                          (hold_q == HOLD_W'(HOLD_MAX - 1));
`else
    assign wdt_expire_c = 1'b0;
`endif

    // Next-state and grant bookkeeping.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        served_d  = served_q;
        err_d     = err_q;
        ptr_d     = ptr_q;
        overrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_open_c) begin
                    state_d  = ST_ARB;
                    served_d = '0;
                    err_d    = '0;
                end
            end
            ST_ARB: begin
                if (win_close_c) begin
                    state_d = ST_IDLE;
                end else if (pick_valid_c) begin
                    gnt_d   = pick_onehot_c;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (done_hit_c) begin
                    gnt_d    = '0;
                    served_d = served_q | gnt_q;
                    ptr_d    = ptr_adv_c;
                    state_d  = win_close_c ? ST_IDLE : ST_ARB;
                end else if (wdt_expire_c) begin
                    gnt_d     = '0;
                    served_d  = served_q | gnt_q;
                    err_d     = err_q | gnt_q;
                    ptr_d     = ptr_adv_c;
                    overrun_d = 1'b1;
                    state_d   = win_close_c ? ST_IDLE : ST_ARB;
                end else if (win_close_c) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (done_hit_c) begin
                    gnt_d = '0;
                    ptr_d = ptr_adv_c;
                    if (win_open_c) begin
                        served_d = '0;
                        err_d    = '0;
                        state_d  = ST_ARB;
                    end else begin
                        served_d = served_q | gnt_q;
                        state_d  = ST_IDLE;
                    end
                end else if (win_open_c) begin
                    // New frame arrived with the old grant still held: revoke it.
                    gnt_d     = '0;
                    served_d  = '0;
                    err_d     = gnt_q;
                    ptr_d     = ptr_adv_c;
                    overrun_d = 1'b1;
                    state_d   = ST_ARB;
                end else if (wdt_expire_c) begin
                    gnt_d     = '0;
                    served_d  = served_q | gnt_q;
                    err_d     = err_q | gnt_q;
                    ptr_d     = ptr_adv_c;
                    overrun_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // FSM and grant state registers.
    always_ff @(posedge pixClk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            served_q  <= '0;
            err_q     <= '0;
            ptr_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            served_q  <= served_d;
            err_q     <= err_d;
            ptr_q     <= ptr_d;
            overrun_q <= overrun_d;
        end
    end

    // Registered window status and frame tick.
    always_ff @(posedge pixClk or posedge rst) begin
        if (rst) begin
            frame_tick_q <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            frame_tick_q <= win_open_c;
            if (win_open_c) begin
                win_q <= 1'b1;
            end else if (win_close_c) begin
                win_q <= 1'b0;
            end
        end
    end

    assign gnt         = gnt_q;
    assign frame_tick  = frame_tick_q;
    assign window_open = win_q;
    assign overrun     = overrun_q;
    assign err_mask    = err_q;

endmodule

// File: tb/tb_vblank_scheduler.sv
// Scoreboard bench for vblank_scheduler using a compressed 8-pixel line timing.
module tb_vblank_scheduler;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned H_TOT = 8;
    localparam int unsigned V_TOT = 525;
    localparam int unsigned HOLD  = 16;

    logic            pixClk = 1'b0;
    logic            rst;
    logic [10:0]     horiz_counter;
    logic [10:0]     vert_counter;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] gnt;
    logic            frame_tick;
    logic            window_open;
    logic            overrun;
    logic [NREQ-1:0] err_mask;

    int n_checks   = 0;
    int n_fail     = 0;
    int tick_cnt   = 0;
    int ovr_cnt    = 0;
    int gnt_events = 0;

    logic [NREQ-1:0] exp_q[$];
    logic [NREQ-1:0] prev_gnt = '0;

    vblank_scheduler #(
        .vDisp    (480),
        .vWinEnd  (520),
        .NREQ     (NREQ),
        .HOLD_MAX (HOLD)
    ) dut (
        .pixClk        (pixClk),
        .rst           (rst),
        .horiz_counter (horiz_counter),
        .vert_counter  (vert_counter),
        .req           (req),
        .done          (done),
        .gnt           (gnt),
        .frame_tick    (frame_tick),
        .window_open   (window_open),
        .overrun       (overrun),
        .err_mask      (err_mask)
    );

    always #5 pixClk = ~pixClk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t line=%0d hc=%0d)",
                     tag, got, exp, $time, vert_counter, horiz_counter);
        end
    endtask

    // Compressed VGA timing: counters advance on the falling edge.
    initial begin
        horiz_counter = '0;
        vert_counter  = '0;
        forever begin
            @(negedge pixClk);
            if (horiz_counter == 11'(H_TOT - 1)) begin
                horiz_counter = '0;
                vert_counter  = (vert_counter == 11'(V_TOT - 1)) ? 11'd0 : vert_counter + 11'd1;
            end else begin
                horiz_counter = horiz_counter + 11'd1;
            end
        end
    end

    // Output monitor: pulse counters and grant-order scoreboard.
    initial begin
        forever begin
            @(posedge pixClk);
            #1;
            if (frame_tick === 1'b1) tick_cnt++;
            if (overrun === 1'b1) ovr_cnt++;
            if ($countones(gnt) > 1) check_eq("gnt_onehot", 32'($countones(gnt)), 32'd1);
            if (gnt !== prev_gnt && gnt !== '0) begin
                gnt_events++;
                if (exp_q.size() == 0) check_eq("gnt_unexpected", 32'(gnt), 32'd0);
                else check_eq("gnt_order", 32'(gnt), 32'(exp_q.pop_front()));
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge pixClk);
        #1;
    endtask

    task automatic wait_line(input int unsigned line);
        int n;
        n = 0;
        while (!(vert_counter == 11'(line) && horiz_counter == '0) && n < 6000) begin
            tick();
            n++;
        end
        if (n >= 6000) check_eq("line_timeout", 32'(vert_counter), 32'(line));
    endtask

    task automatic wait_gnt(output logic [NREQ-1:0] g);
        int n;
        n = 0;
        while (gnt == '0 && n < 400) begin
            tick();
            n++;
        end
        g = gnt;
        if (gnt == '0) check_eq("gnt_timeout", 32'(gnt != '0), 32'd1);
    endtask

    // Requester side: drop req on grant, pulse done dly cycles later.
    task automatic serve(input logic [NREQ-1:0] g, input int dly);
        req = req & ~g;
        repeat (dly - 1) tick();
        done = g;
        tick();
        done = '0;
        check_eq("gnt_clear_after_done", 32'(gnt), 32'd0);
    endtask

    task automatic serve_n(input int n);
        logic [NREQ-1:0] g;
        for (int k = 0; k < n; k++) begin
            wait_gnt(g);
            serve(g, 10);
        end
    endtask

    initial begin
        logic [NREQ-1:0] g;
        int t0;
        int ev0;

        rst  = 1'b1;
        req  = '0;
        done = '0;
        repeat (3) tick();
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_frame_tick", 32'(frame_tick), 32'd0);
        check_eq("rst_window_open", 32'(window_open), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        check_eq("rst_err_mask", 32'(err_mask), 32'd0);
        rst = 1'b0;

        // Frame 1: all four request, granted 0..3 in order.
        req = 4'b1111;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        t0  = tick_cnt;
        ev0 = gnt_events;
        wait_line(480);
        check_eq("f1_tick_before_open", 32'(frame_tick), 32'd0);
        check_eq("f1_win_before_open", 32'(window_open), 32'd0);
        tick();
        check_eq("f1_frame_tick", 32'(frame_tick), 32'd1);
        check_eq("f1_window_open", 32'(window_open), 32'd1);
        tick();
        check_eq("f1_frame_tick_pulse", 32'(frame_tick), 32'd0);
        serve_n(4);
        // Re-request from an already served requester: no second grant this frame.
        req = 4'b0001;
        wait_line(521);
        check_eq("f1_win_at_close", 32'(window_open), 32'd1);
        tick();
        check_eq("f1_win_closed", 32'(window_open), 32'd0);
        check_eq("f1_tick_count", 32'(tick_cnt - t0), 32'd1);
        check_eq("f1_grant_count", 32'(gnt_events - ev0), 32'd4);
        check_eq("f1_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // Frame 2: carried-over req[0], then a late grant on line 520 that drains.
        exp_q.push_back(4'b0001);
        wait_line(480);
        serve_n(1);
        wait_line(520);
        req = 4'b0010;
        exp_q.push_back(4'b0010);
        wait_gnt(g);
        check_eq("f2_late_gnt_line", 32'(vert_counter), 32'd520);
        req = '0;
        wait_line(521);
        tick();
        tick();
        check_eq("f2_drain_window", 32'(window_open), 32'd0);
        check_eq("f2_drain_gnt", 32'(gnt), 32'b0010);
        done = 4'b0010;
        tick();
        done = '0;
        check_eq("f2_drain_gnt_clear", 32'(gnt), 32'd0);
        check_eq("f2_no_overrun", 32'(ovr_cnt), 32'd0);
        check_eq("f2_err_mask", 32'(err_mask), 32'd0);

        // Frame 3: pointer at 2, req 0101 -> 0100 then 0001.
        req = 4'b0101;
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0001);
        wait_line(480);
        serve_n(2);

        // Frame 4: requester 0 granted and never completes.
        req = 4'b0001;
        exp_q.push_back(4'b0001);
        wait_line(480);
        wait_gnt(g);
        req = '0;
`ifdef VBLANK_SCHED_WDT_EN
        repeat (HOLD - 1) tick();
        check_eq("wdt_gnt_last_cycle", 32'(gnt), 32'b0001);
        tick();
        check_eq("wdt_gnt_revoked", 32'(gnt), 32'd0);
        check_eq("wdt_overrun", 32'(overrun), 32'd1);
        check_eq("wdt_err_mask", 32'(err_mask), 32'b0001);
        req = 4'b1110;
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        serve_n(3);
        wait_line(480);
        tick();
        check_eq("f5_frame_tick", 32'(frame_tick), 32'd1);
        check_eq("f5_err_cleared", 32'(err_mask), 32'd0);
        check_eq("f5_no_overrun", 32'(overrun), 32'd0);
`else
        repeat (40) tick();
        check_eq("nowdt_gnt_held", 32'(gnt), 32'b0001);
        req = 4'b1110;
        wait_line(521);
        tick();
        tick();
        check_eq("f4_drain_window", 32'(window_open), 32'd0);
        check_eq("f4_drain_gnt", 32'(gnt), 32'b0001);
        check_eq("f4_no_overrun_yet", 32'(ovr_cnt), 32'd0);
        // Frame 5: forced revocation at window open, others served normally.
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        wait_line(480);
        tick();
        check_eq("f5_frame_tick", 32'(frame_tick), 32'd1);
        check_eq("f5_overrun", 32'(overrun), 32'd1);
        check_eq("f5_gnt_revoked", 32'(gnt), 32'd0);
        check_eq("f5_err_mask", 32'(err_mask), 32'b0001);
        serve_n(3);
        check_eq("f5_err_mask_sticky", 32'(err_mask), 32'b0001);
`endif
        check_eq("overrun_once", 32'(ovr_cnt), 32'd1);

        // Frame 6: grant to requester 3, then reset while it is held.
        req = 4'b1000;
        exp_q.push_back(4'b1000);
        wait_line(480);
        tick();
        check_eq("f6_err_cleared", 32'(err_mask), 32'd0);
        wait_gnt(g);
        check_eq("f6_gnt_before_rst", 32'(gnt), 32'b1000);
        rst = 1'b1;
        #1;
        check_eq("rst_async_gnt", 32'(gnt), 32'd0);
        check_eq("rst_async_window", 32'(window_open), 32'd0);
        check_eq("rst_async_tick", 32'(frame_tick), 32'd0);
        check_eq("rst_async_overrun", 32'(overrun), 32'd0);
        check_eq("rst_async_err", 32'(err_mask), 32'd0);
        req = 4'b1111;
        repeat (3) tick();
        rst = 1'b0;
        ev0 = gnt_events;
        wait_line(480);
        check_eq("rst_no_early_gnt", 32'(gnt_events - ev0), 32'd0);
        check_eq("rst_gnt_idle", 32'(gnt), 32'd0);

        // Frame 7: pointer back at 0 after reset.
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        tick();
        check_eq("f7_frame_tick", 32'(frame_tick), 32'd1);
        serve_n(4);
        check_eq("f7_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check_eq("f7_no_overrun", 32'(ovr_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
